id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the five-stage L1-cached pipeline CPU. It captures decoded operands, register specifiers and control from ID and presents them to EX and the forwarding logic as `ID_EX_*` values. It also generates the PC and IF/ID write enables, and inserts bubbles or freezes on load-use hazards, branch flushes and cache-miss stalls. Two saturating counters record bubble and freeze cycles for performance reporting.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline definitions for the five-stage CPU.
// Holds the bit positions of the decoded control byte carried from ID
// through EX/MEM, plus the register-specifier width. Used by the ID/EX
// stage, the forwarding unit and the EX/MEM stage.
package cpu_pkg;

  localparam int CTRL_W        = 8;
  localparam int REG_W         = 5;

  // Control byte layout: {RegWrite, MemtoReg, MemRead, MemWrite,
  //                       RegDst, ALUSrc, ALUOp[1:0]}
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard check.
// Flags when the instruction in EX is a valid load whose destination
// (Rt, non-zero) is a source of the instruction currently in ID.
// Ports:
//   ex_mem_read_i  MemRead bit of the instruction in EX
//   ex_valid_i     EX slot holds a real instruction
//   ex_rt_i        load destination register in EX
//   id_rs_i/id_rt_i source specifiers of the instruction in ID
//   lu_o           hazard detected
module load_use_detect
  import cpu_pkg::*;
(
  input  logic             ex_mem_read_i,
  input  logic             ex_valid_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             lu_o
);

  // $0 is hardwired to zero, so a load into it never creates a dependency.
  assign lu_o = ex_mem_read_i & ex_valid_i & (ex_rt_i != '0) &
                ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard handling.
// Captures operands, specifiers and control from ID, presents them to EX
// and forwarding, drives the PC / IF-ID write enables, inserts bubbles on
// load-use hazards and branch flushes, freezes on cache-miss stalls, and
// counts bubble and freeze cycles with saturating counters.
// Ports:
//   clk_i, rst_i (async, active-low)
//   mem_stall_i, flush_i                  pipeline freeze / branch kill
//   IF_ID_RegisterRs/Rt, rd_i             specifiers from ID
//   ctrl_i, data1_i, data2_i, imm_i       decoded control and operands
//   ID_EX_RegisterRs/Rt/Rd, ctrl_o,
//   data1_o, data2_o, imm_o, valid_o      registered EX-stage slot
//   pc_write_o, if_id_write_o             combinational upstream enables
//   bubble_cnt_o, freeze_cnt_o            saturating performance counters
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  input  logic [REG_W-1:0]  IF_ID_RegisterRs,
  input  logic [REG_W-1:0]  IF_ID_RegisterRt,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic [REG_W-1:0]  ID_EX_RegisterRs,
  output logic [REG_W-1:0]  ID_EX_RegisterRt,
  output logic [REG_W-1:0]  ID_EX_RegisterRd,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              valid_o,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  freeze_cnt_o
);

  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  freeze_cnt_q, freeze_cnt_d;
  logic              lu;

  load_use_detect u_lu (
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_valid_i    (valid_q),
    .ex_rt_i       (rt_q),
    .id_rs_i       (IF_ID_RegisterRs),
    .id_rt_i       (IF_ID_RegisterRt),
    .lu_o          (lu)
  );

  always_comb begin
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    ctrl_d       = ctrl_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    imm_d        = imm_q;
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (mem_stall_i) begin
      if (freeze_cnt_q != '1) freeze_cnt_d = freeze_cnt_q + 1'b1;
    end else begin
      rs_d    = IF_ID_RegisterRs;
      rt_d    = IF_ID_RegisterRt;
      rd_d    = rd_i;
      data1_d = data1_i;
      data2_d = data2_i;
      imm_d   = imm_i;
      if (flush_i || lu) begin
        // Zero control guarantees no RegWrite/MemWrite, so forwarding
        // and memory never act on the killed slot.
        ctrl_d  = '0;
        valid_d = 1'b0;
        // A flush supersedes the hazard: the consumer is being discarded.
        if (!flush_i && bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
      end else begin
        ctrl_d  = ctrl_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      imm_q        <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
      freeze_cnt_q <= '0;
    end else begin
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      imm_q        <= imm_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  // Enables read 1 during reset regardless of a stall request, so fetch
  // is ready to go on the first post-reset edge.
  assign pc_write_o    = !rst_i | (!mem_stall_i & (flush_i | !lu));
  assign if_id_write_o = pc_write_o;

  assign ID_EX_RegisterRs = rs_q;
  assign ID_EX_RegisterRt = rt_q;
  assign ID_EX_RegisterRd = rd_q;
  assign ctrl_o           = ctrl_q;
  assign data1_o          = data1_q;
  assign data2_o          = data2_q;
  assign imm_o            = imm_q;
  assign valid_o          = valid_q;
  assign bubble_cnt_o     = bubble_cnt_q;
  assign freeze_cnt_o     = freeze_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage. The driver computes the expected
// EX-slot contents from the pipeline rules and queues them; a separate
// monitor pops and compares after each clock edge.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              mem_stall_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [4:0]        if_rs = '0, if_rt = '0, rd_i = '0;
  logic [7:0]        ctrl_i = '0;
  logic [DATA_W-1:0] data1_i = '0, data2_i = '0, imm_i = '0;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [7:0]        ctrl_o;
  logic [DATA_W-1:0] data1_o, data2_o, imm_o;
  logic              valid_o, pc_write_o, if_id_write_o;
  logic [CNT_W-1:0]  bubble_cnt_o, freeze_cnt_o;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .mem_stall_i      (mem_stall_i),
    .flush_i          (flush_i),
    .IF_ID_RegisterRs (if_rs),
    .IF_ID_RegisterRt (if_rt),
    .ctrl_i           (ctrl_i),
    .data1_i          (data1_i),
    .data2_i          (data2_i),
    .imm_i            (imm_i),
    .rd_i             (rd_i),
    .ID_EX_RegisterRs (ex_rs),
    .ID_EX_RegisterRt (ex_rt),
    .ID_EX_RegisterRd (ex_rd),
    .ctrl_o           (ctrl_o),
    .data1_o          (data1_o),
    .data2_o          (data2_o),
    .imm_o            (imm_o),
    .valid_o          (valid_o),
    .pc_write_o       (pc_write_o),
    .if_id_write_o    (if_id_write_o),
    .bubble_cnt_o     (bubble_cnt_o),
    .freeze_cnt_o     (freeze_cnt_o)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [7:0]  ctrl;
    logic [31:0] d1, d2, imm;
    logic        valid;
    int          bub, frz;
    bit          full;   // specifiers/data are meaningful to compare
  } exp_t;

  exp_t m;
  exp_t exp_q[$];
  bit   we_q[$];
  exp_t mon_e;
  bit   mon_w;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m = '{rs: 0, rt: 0, rd: 0, ctrl: 0, d1: 0, d2: 0, imm: 0, valid: 0, bub: 0, frz: 0, full: 1};
  endtask

  // One ID-stage cycle: drive inputs, then predict the enables for this
  // cycle and the EX slot after the next edge.
  task automatic cycle(input bit stall, input bit flush, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [7:0] ctrl, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm);
    bit haz;
    @(negedge clk);
    #1;
    rst_i = 1'b1;
    mem_stall_i = stall; flush_i = flush;
    if_rs = rs; if_rt = rt; rd_i = rd; ctrl_i = ctrl;
    data1_i = d1; data2_i = d2; imm_i = imm;
    haz = m.valid && m.ctrl[CTRL_MEMREAD] && (m.rt != 0) && (m.rt == rs || m.rt == rt);
    we_q.push_back(!stall && (flush || !haz));
    if (stall) begin
      m.frz = (m.frz < CNT_MAX) ? m.frz + 1 : CNT_MAX;
    end else begin
      m.rs = rs; m.rt = rt; m.rd = rd; m.d1 = d1; m.d2 = d2; m.imm = imm;
      if (flush) begin
        m.ctrl = 0; m.valid = 0; m.full = 1;
      end else if (haz) begin
        m.ctrl = 0; m.valid = 0; m.full = 0;
        m.bub = (m.bub < CNT_MAX) ? m.bub + 1 : CNT_MAX;
      end else begin
        m.ctrl = ctrl; m.valid = 1; m.full = 1;
      end
    end
    exp_q.push_back(m);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rs"}, ex_rs, 0);
    check({tag, "_rt"}, ex_rt, 0);
    check({tag, "_rd"}, ex_rd, 0);
    check({tag, "_ctrl"}, ctrl_o, 0);
    check({tag, "_data1"}, data1_o, 0);
    check({tag, "_data2"}, data2_o, 0);
    check({tag, "_imm"}, imm_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_bubble_cnt"}, bubble_cnt_o, 0);
    check({tag, "_freeze_cnt"}, freeze_cnt_o, 0);
    check({tag, "_pc_write"}, pc_write_o, 1);
    check({tag, "_if_id_write"}, if_id_write_o, 1);
  endtask

  // Monitor: enables mid-cycle, registered slot just after each edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (we_q.size() > 0) begin
        mon_w = we_q.pop_front();
        check("pc_write", pc_write_o, mon_w);
        check("if_id_write", if_id_write_o, mon_w);
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("ctrl", ctrl_o, mon_e.ctrl);
        check("valid", valid_o, mon_e.valid);
        check("bubble_cnt", bubble_cnt_o, mon_e.bub);
        check("freeze_cnt", freeze_cnt_o, mon_e.frz);
        if (mon_e.full) begin
          check("rs", ex_rs, mon_e.rs);
          check("rt", ex_rt, mon_e.rt);
          check("rd", ex_rd, mon_e.rd);
          check("data1", data1_o, mon_e.d1);
          check("data2", data2_o, mon_e.d2);
          check("imm", imm_o, mon_e.imm);
        end
      end
    end
  end

  initial begin
    model_reset();
    mem_stall_i = 1'b1;
    #12;
    check_reset_state("por");
    mem_stall_i = 1'b0;

    // add $3,$1,$2
    cycle(0, 0, 5'd1, 5'd2, 5'd3, 8'h88, 32'h11, 32'h22, 32'h0);
    // lw $5 then a consumer of $5: one bubble, then the consumer loads
    cycle(0, 0, 5'd1, 5'd5, 5'd0, 8'hE4, 32'h100, 32'h0, 32'h8);
    cycle(0, 0, 5'd5, 5'd6, 5'd7, 8'h88, 32'hA5, 32'h5A, 32'h0);
    cycle(0, 0, 5'd5, 5'd6, 5'd7, 8'h88, 32'hA5, 32'h5A, 32'h0);
    // lw $0 then use of $0: no bubble
    cycle(0, 0, 5'd2, 5'd0, 5'd0, 8'hE4, 32'h200, 32'h0, 32'h4);
    cycle(0, 0, 5'd0, 5'd0, 5'd9, 8'h88, 32'h0, 32'h0, 32'h0);
    // lw $7, freeze 10 with consumer waiting, then exactly one bubble
    cycle(0, 0, 5'd3, 5'd7, 5'd0, 8'hE4, 32'h300, 32'h0, 32'hC);
    for (int i = 0; i < 10; i++) cycle(1, 0, 5'd8, 5'd7, 5'd4, 8'h88, 32'h1, 32'h2, 32'h0);
    cycle(0, 0, 5'd8, 5'd7, 5'd4, 8'h88, 32'h1, 32'h2, 32'h0);
    cycle(0, 0, 5'd8, 5'd7, 5'd4, 8'h88, 32'h1, 32'h2, 32'h0);
    // lw $4 then flush together with a hazard
    cycle(0, 0, 5'd1, 5'd4, 5'd0, 8'hE4, 32'h400, 32'h0, 32'h10);
    cycle(0, 1, 5'd4, 5'd2, 5'd6, 8'h88, 32'h7, 32'h8, 32'h0);
    // long freeze saturates the counter
    for (int i = 0; i < 20; i++) cycle(1, 0, 5'd1, 5'd2, 5'd3, 8'h88, 32'h9, 32'h9, 32'h9);
    // reset in the middle of a stall clears without a clock edge
    @(negedge clk);
    #1;
    mem_stall_i = 1'b1;
    rst_i = 1'b0;
    #1;
    check_reset_state("mid_stall_rst");
    model_reset();
    cycle(0, 0, 5'd1, 5'd2, 5'd3, 8'h88, 32'hDEAD, 32'hBEEF, 32'h1);

    // randomized traffic with a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [7:0] c;
      c = 8'($urandom);
      c[CTRL_MEMREAD] = ($urandom_range(0, 9) < 4);
      cycle(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            c, $urandom, $urandom, $urandom);
    end

    repeat (3) @(negedge clk);
    check("queues_drained", 64'(exp_q.size() + we_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
